sprite_anim_addr: RTL and testbench
===================================

# sprite_anim_addr

- Generates the 17-bit ROM address for one animated character sprite, such as the jump sequence, from the current VGA draw coordinate, the sprite screen position and an internal animation-frame sequencer.
- Sits upstream of the sprite ROM/palette/RGB renderer and drives its `rom_address`.
- Emits a `sprite_on` qualifier delayed to line up with the renderer's registered RGB, so the top-level mux can composite sprite over background.

## Interface
Parameters:
- FRAME_W, 96: sprite frame width in pixels
- FRAME_H, 128: sprite frame height in pixels
- NUM_FRAMES, 8: frames in the sequence; requires FRAME_W·FRAME_H·NUM_FRAMES ≤ 131072
- HOLD_TICKS, 4: vsync rising edges each frame is shown
- TRANSP_IDX, 0: palette index treated as transparent (package constant, informational)

Ports:
- vga_clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; (re)starts the sequence at frame 0
- flip  in  1  1 = mirror horizontally (facing left)
- vsync  in  1  VGA vsync level; rising edge is the animation tick
- draw_x  in  10  current pixel column
- draw_y  in  10  current pixel row
- pos_x  in  10  sprite top-left column
- pos_y  in  10  sprite top-left row
- rom_address  out  17  address to sprite ROM
- sprite_on  out  1  pixel inside sprite box, aligned to renderer RGB output
- busy  out  1  sequencer in PLAY
- done  out  1  one-cycle pulse when last frame's hold expires

## Operation
- FSM states:
  - IDLE: frame=0. start → PLAY.
  - PLAY: a tick counter counts vsync rising edges. At HOLD_TICKS edges the counter clears and the frame advances. If frame==NUM_FRAMES-1 when the hold expires, go to DONE and pulse done.
  - DONE: holds the last frame. start → PLAY at frame 0.
- start in any state clears the tick counter and sets frame=0.
- start coincident with a vsync edge: start wins; that edge is not counted.
- Vsync edge detection: register vsync once and compare current vs previous. The first cycle after reset never reports an edge.
- frame_base register:
  - cleared alongside frame=0;
  - incremented by FRAME_W·FRAME_H on each frame advance.
  - No run-time multiply by frame index.
- Box test, computed in 11-bit unsigned to prevent wrap at screen edge:
  - in_box = (draw_x ≥ pos_x) & (draw_x < pos_x+FRAME_W) & (draw_y ≥ pos_y) & (draw_y < pos_y+FRAME_H).
  - Boxes partly off-screen are simply clipped.
- dx = draw_x−pos_x and dy = draw_y−pos_y. With flip=1, dx' = FRAME_W−1−dx; otherwise dx' = dx.
- rom_address = frame_base + dy·FRAME_W + dx' when in_box, else 0. The multiply is by a constant.
- Frame changes take effect only on a vsync edge. Changes to draw_x/draw_y/pos/flip affect only the address pipeline.

## Timing
- Stage 1, posedge N+1: register in_box, dx', dy, sampled from draw_x/draw_y at edge N.
- Stage 2, posedge N+2: register rom_address and in_box_d.
- The renderer's ROM reads on negedge in cycle N+2 and registers RGB at N+3. sprite_on is therefore in_box delayed one more register, valid at N+3. Address latency is 2 cycles; sprite_on latency is 3.
- done: asserted for exactly one cycle, the cycle after the final hold-expiring vsync edge, coincident with entry to DONE.
- busy is high exactly while the FSM is in PLAY.
- Reset values: rom_address=0, sprite_on=0, busy=0, done=0, FSM=IDLE, frame=0, frame_base=0, tick counter=0, vsync history=0, pipeline valids=0.
- Reset mid-PLAY aborts immediately to IDLE; done does not pulse.

## Structure
- Shared package `sprite_pkg`:
  - FSM enum `anim_state_t` (IDLE, PLAY, DONE);
  - address width constant ROM_AW=17;
  - coordinate width COORD_W=10;
  - TRANSP_IDX.
- Natural sub-module `anim_sequencer`: FSM, tick counter, frame/frame_base, done/busy.
- The top level holds the box test and the 3-stage address pipeline.

## Test plan
- Reset, then draw (100,50) with pos (100,50), flip=0 → rom_address=0 two cycles later; sprite_on=1 three cycles later.
- Draw (195,177), pos (100,50), frame 0 → address 127·96+95=12287. With flip=1 → 12192.
- Draw (196,50), pos (100,50) → outside box; rom_address=0, sprite_on=0. Pos (600,50) with draw (639,60) → in box, dx=39.
- start, then 4 vsync rising edges → frame_base=12288 and busy=1. After 32 total edges → DONE, done high one cycle, busy=0, frame_base=86016.
- start asserted on the same cycle as a vsync edge in PLAY at frame 5 → frame=0, tick counter=0, that edge not counted.
- reset asserted mid-PLAY at frame 3 → next cycle IDLE, frame_base=0, done never pulses.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the animated sprite address generator.
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } anim_state_t;

  localparam int unsigned ROM_AW     = 17;
  localparam int unsigned COORD_W    = 10;
  localparam int unsigned TRANSP_IDX = 0;

endpackage

// File: rtl/anim_sequencer.sv
// Animation-frame sequencer: counts vsync ticks, steps frames, tracks frame_base.
module anim_sequencer
  import sprite_pkg::*;
#(
  parameter int unsigned FRAME_W    = 96,
  parameter int unsigned FRAME_H    = 128,
  parameter int unsigned NUM_FRAMES = 8,
  parameter int unsigned HOLD_TICKS = 4
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              vsync,
  output logic [ROM_AW-1:0] frame_base,
  output logic              busy,
  output logic              done
);

  localparam int unsigned TICK_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam int unsigned FRM_W  = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam logic [ROM_AW-1:0] FRAME_SZ  = ROM_AW'(FRAME_W * FRAME_H);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(HOLD_TICKS - 1);
  localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(NUM_FRAMES - 1);

  anim_state_t       state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [FRM_W-1:0]  frame_q, frame_d;
  logic [ROM_AW-1:0] base_d;
  logic              done_d;
  logic              vsync_q;
  logic              hist_vld_q;
  logic              vsync_edge_c;

  // Rising edge of vsync; suppressed until the history register holds a real sample.
  assign vsync_edge_c = vsync & ~vsync_q & hist_vld_q;

  // State, counters and registered status outputs.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      frame_q    <= '0;
      frame_base <= '0;
      vsync_q    <= 1'b0;
      hist_vld_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      frame_q    <= frame_d;
      frame_base <= base_d;
      vsync_q    <= vsync;
      hist_vld_q <= 1'b1;
      busy       <= (state_d == PLAY);
      done       <= done_d;
    end
  end

  // Next-state logic; start overrides everything, including a coincident tick.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    frame_d = frame_q;
    base_d  = frame_base;
    done_d  = 1'b0;
    if (start) begin
      state_d = PLAY;
      tick_d  = '0;
      frame_d = '0;
      base_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          frame_d = '0;
          base_d  = '0;
        end
        PLAY: begin
          if (vsync_edge_c) begin
            if (tick_q == TICK_LAST) begin
              tick_d = '0;
              if (frame_q == FRM_LAST) begin
                state_d = DONE;
                done_d  = 1'b1;
              end else begin
                frame_d = frame_q + FRM_W'(1);
                base_d  = frame_base + FRAME_SZ;
              end
            end else begin
              tick_d = tick_q + TICK_W'(1);
            end
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/sprite_anim_addr.sv
// Sprite ROM address generator: box test plus address / sprite_on pipeline.
module sprite_anim_addr
  import sprite_pkg::*;
#(
  parameter int unsigned FRAME_W    = 96,
  parameter int unsigned FRAME_H    = 128,
  parameter int unsigned NUM_FRAMES = 8,
  parameter int unsigned HOLD_TICKS = 4
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic               start,
  input  logic               flip,
  input  logic               vsync,
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  output logic [ROM_AW-1:0]  rom_address,
  output logic               sprite_on,
  output logic               busy,
  output logic               done
);

  localparam int unsigned BOX_W = COORD_W + 1;

  logic [ROM_AW-1:0]  frame_base;
  logic [BOX_W-1:0]   x_c, y_c, px_c, py_c;
  logic               in_box_c;
  logic [COORD_W-1:0] dx_c, dxf_c, dy_c;
  logic               s1_in_box;
  logic [COORD_W-1:0] s1_dx, s1_dy;
  logic               in_box_d;

  anim_sequencer #(
    .FRAME_W    (FRAME_W),
    .FRAME_H    (FRAME_H),
    .NUM_FRAMES (NUM_FRAMES),
    .HOLD_TICKS (HOLD_TICKS)
  ) u_seq (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .start      (start),
    .vsync      (vsync),
    .frame_base (frame_base),
    .busy       (busy),
    .done       (done)
  );

  // Box test widened by one bit so a sprite near the right/bottom edge does not wrap.
  always_comb begin
    x_c      = {1'b0, draw_x};
    y_c      = {1'b0, draw_y};
    px_c     = {1'b0, pos_x};
    py_c     = {1'b0, pos_y};
    in_box_c = (x_c >= px_c) && (x_c < px_c + BOX_W'(FRAME_W)) &&
               (y_c >= py_c) && (y_c < py_c + BOX_W'(FRAME_H));
    dx_c     = draw_x - pos_x;
    dy_c     = draw_y - pos_y;
    dxf_c    = flip ? (COORD_W'(FRAME_W - 1) - dx_c) : dx_c;
  end

  // Stage 1: capture box flag and in-frame offsets.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      s1_in_box <= 1'b0;
      s1_dx     <= '0;
      s1_dy     <= '0;
    end else begin
      s1_in_box <= in_box_c;
      s1_dx     <= dxf_c;
      s1_dy     <= dy_c;
    end
  end

  // Stage 2: form the ROM address (constant multiply by frame width).
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rom_address <= '0;
      in_box_d    <= 1'b0;
    end else begin
      rom_address <= s1_in_box
                   ? frame_base + ROM_AW'(s1_dy) * ROM_AW'(FRAME_W) + ROM_AW'(s1_dx)
                   : '0;
      in_box_d    <= s1_in_box;
    end
  end

  // Stage 3: align sprite_on with the renderer's registered RGB.
  always_ff @(posedge vga_clk) begin
    if (reset) sprite_on <= 1'b0;
    else       sprite_on <= in_box_d;
  end

endmodule

// File: tb/tb_sprite_anim_addr.sv
// Directed bench for sprite_anim_addr with a latency-tagged expectation queue.
module tb_sprite_anim_addr;

  logic        vga_clk;
  logic        reset, start, flip, vsync;
  logic [9:0]  draw_x, draw_y, pos_x, pos_y;
  logic [16:0] rom_address;
  logic        sprite_on, busy, done;

  typedef struct {
    int          due;
    logic [16:0] val;
    string       tag;
  } exp_t;

  exp_t aq[$];
  exp_t oq[$];
  exp_t mon_e;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic seen_done = 1'b0;

  sprite_anim_addr dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .start       (start),
    .flip        (flip),
    .vsync       (vsync),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .rom_address (rom_address),
    .sprite_on   (sprite_on),
    .busy        (busy),
    .done        (done)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  // Reference box/address model for a 96x128 frame.
  function automatic bit m_in(input int x, y, px, py);
    return (x >= px) && (x < px + 96) && (y >= py) && (y < py + 128);
  endfunction

  function automatic int m_addr(input int x, y, px, py, input bit f, input int base);
    int dx, dy;
    dx = x - px;
    dy = y - py;
    if (!m_in(x, y, px, py)) return 0;
    return base + dy * 96 + (f ? (95 - dx) : dx);
  endfunction

  // Scoreboard: compare queued expectations when their cycle arrives.
  always @(negedge vga_clk) begin
    while (aq.size() > 0 && aq[0].due <= cyc) begin
      mon_e = aq.pop_front();
      n_cmp++;
      assert (rom_address === mon_e.val) else begin
        n_bad++;
        $error("FAIL %s rom_address: observed %0d expected %0d", mon_e.tag, rom_address, mon_e.val);
      end
    end
    while (oq.size() > 0 && oq[0].due <= cyc) begin
      mon_e = oq.pop_front();
      n_cmp++;
      assert ({16'd0, sprite_on} === mon_e.val) else begin
        n_bad++;
        $error("FAIL %s sprite_on: observed %0d expected %0d", mon_e.tag, sprite_on, mon_e.val);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one pixel and queue its address (2 cycles) and sprite_on (3 cycles).
  task automatic pixel(input int x, y, px, py, input logic f, input int ea, input int eo,
                       input string tag);
    draw_x = 10'(x);
    draw_y = 10'(y);
    pos_x  = 10'(px);
    pos_y  = 10'(py);
    flip   = f;
    aq.push_back('{cyc + 2, 17'(ea), tag});
    oq.push_back('{cyc + 3, 17'(eo), tag});
    @(negedge vga_clk);
  endtask

  task automatic drain();
    repeat (4) @(negedge vga_clk);
  endtask

  // Frame base seen through the address of the sprite's top-left pixel.
  task automatic base_chk(input int exp, input string tag);
    pixel(200, 100, 200, 100, 1'b0, exp, 1, tag);
    drain();
  endtask

  task automatic vs_pulse(input int n);
    for (int i = 0; i < n; i++) begin
      vsync = 1'b1;
      @(negedge vga_clk);
      seen_done = seen_done | done;
      vsync = 1'b0;
      @(negedge vga_clk);
      seen_done = seen_done | done;
    end
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge vga_clk);
    start = 1'b0;
    @(negedge vga_clk);
  endtask

  initial begin
    int x, y, px, py;
    logic f;
    reset = 1'b1; start = 1'b0; flip = 1'b0; vsync = 1'b0;
    draw_x = '0; draw_y = '0; pos_x = '0; pos_y = '0;
    repeat (3) @(negedge vga_clk);
    chk("reset_addr", 32'(rom_address), 0);
    chk("reset_on",   32'(sprite_on),   0);
    chk("reset_busy", 32'(busy),        0);
    chk("reset_done", 32'(done),        0);
    reset = 1'b0;
    @(negedge vga_clk);

    // Address path, back-to-back pixels.
    pixel(100,  50, 100,  50, 1'b0,     0, 1, "origin");
    pixel(195, 177, 100,  50, 1'b0, 12287, 1, "far_corner");
    pixel(195, 177, 100,  50, 1'b1, 12192, 1, "far_corner_flip");
    pixel(196,  50, 100,  50, 1'b0,     0, 0, "right_out");
    pixel( 99,  50, 100,  50, 1'b0,     0, 0, "left_out");
    pixel(100, 178, 100,  50, 1'b0,     0, 0, "below_out");
    pixel(639,  60, 600,  50, 1'b0,   999, 1, "clip_right");
    pixel(639,  60, 600,  50, 1'b1,  1016, 1, "clip_right_flip");
    pixel(1010,  5, 1000,  0, 1'b0,   490, 1, "edge_x_nowrap");
    pixel(  3, 1020,  0, 1000, 1'b0, 1923, 1, "edge_y_nowrap");
    pixel(  5,  10, 1000,  0, 1'b0,     0, 0, "left_of_edge_box");
    for (int i = 0; i < 8; i++) begin
      px = int'($urandom_range(0, 900));
      py = int'($urandom_range(0, 880));
      x  = px + int'($urandom_range(0, 110)) - 8;
      y  = py + int'($urandom_range(0, 140)) - 8;
      if (x < 0) x = 0;
      if (y < 0) y = 0;
      f  = 1'($urandom_range(0, 1));
      pixel(x, y, px, py, f, m_addr(x, y, px, py, f, 0), int'(m_in(x, y, px, py)), "random");
    end
    drain();

    // Ticks in IDLE do not advance the frame.
    vs_pulse(4);
    chk("idle_busy", 32'(busy), 0);
    base_chk(0, "idle_no_advance");

    // Play through the whole sequence.
    start_pulse();
    chk("start_busy", 32'(busy), 1);
    chk("start_done", 32'(done), 0);
    vs_pulse(4);
    chk("frame1_busy", 32'(busy), 1);
    base_chk(12288, "frame1_base");
    seen_done = 1'b0;
    vs_pulse(27);
    chk("no_early_done", 32'(seen_done), 0);
    chk("frame7_busy", 32'(busy), 1);
    base_chk(86016, "frame7_base");
    vsync = 1'b1;
    @(negedge vga_clk);
    chk("done_pulse", 32'(done), 1);
    chk("done_busy",  32'(busy), 0);
    vsync = 1'b0;
    @(negedge vga_clk);
    chk("done_one_cycle", 32'(done), 0);
    base_chk(86016, "done_holds_last");
    seen_done = 1'b0;
    vs_pulse(4);
    chk("done_state_quiet", 32'(seen_done), 0);
    chk("done_state_busy",  32'(busy), 0);
    base_chk(86016, "done_still_last");

    // Restart, reach frame 5, then start coincident with a tick.
    start_pulse();
    vs_pulse(20);
    base_chk(61440, "frame5_base");
    vs_pulse(2);
    vsync = 1'b1;
    start = 1'b1;
    @(negedge vga_clk);
    start = 1'b0;
    vsync = 1'b0;
    @(negedge vga_clk);
    chk("start_wins_busy", 32'(busy), 1);
    base_chk(0, "start_wins_base");
    vs_pulse(3);
    base_chk(0, "edge_not_counted");
    vs_pulse(1);
    base_chk(12288, "advance_after_restart");

    // Reset in the middle of PLAY.
    vs_pulse(8);
    base_chk(36864, "frame3_base");
    seen_done = 1'b0;
    reset = 1'b1;
    @(negedge vga_clk);
    seen_done = seen_done | done;
    chk("midreset_busy", 32'(busy), 0);
    reset = 1'b0;
    @(negedge vga_clk);
    base_chk(0, "midreset_base");
    vs_pulse(40);
    chk("midreset_no_done", 32'(seen_done), 0);
    chk("midreset_idle",    32'(busy),      0);

    drain();
    chk("addr_queue_empty", 32'(aq.size()), 0);
    chk("on_queue_empty",   32'(oq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
